// File: rtl/sw_debounce_if.sv
// Switch-conditioner signal bundle: raw pins in, debounced level and edge strobes out.
// The slave modport is the debouncer; the master modport is the pin/consumer side.
interface sw_debounce_if #(
    parameter int unsigned SW_WIDTH = 4
);
    logic [SW_WIDTH-1:0] i_sw;
    logic [SW_WIDTH-1:0] o_sw;
    logic [SW_WIDTH-1:0] o_rise;
    logic [SW_WIDTH-1:0] o_fall;
    logic                o_changed;

    modport master (
        output i_sw,
        input  o_sw,
        input  o_rise,
        input  o_fall,
        input  o_changed
    );

    modport slave (
        input  i_sw,
        output o_sw,
        output o_rise,
        output o_fall,
        output o_changed
    );
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus independent per-bit debounce for the board slide switches,
// producing a stable switch vector and single-cycle rise/fall/changed strobes.
module sw_debounce #(
    parameter int unsigned SW_WIDTH       = 4,
    parameter int unsigned DEBOUNCE_COUNT = 1250000,
    parameter int unsigned CNT_WIDTH      = 21
) (
    input logic          clock,
    input logic          i_reset,
    sw_debounce_if.slave sw
);

    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic [SW_WIDTH-1:0]  sync1_q, sync2_q;
    logic [SW_WIDTH-1:0]  sw_q, sw_d;
    logic [SW_WIDTH-1:0]  rise_q, rise_d;
    logic [SW_WIDTH-1:0]  fall_q, fall_d;
    logic                 changed_q, changed_d;
    logic [CNT_WIDTH-1:0] cnt_q [SW_WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [SW_WIDTH];

    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < SW_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != sw_q[i]) begin
                if (cnt_q[i] == LastCnt) begin
                    sw_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
        // Registered alongside the strobes so all three assert on the same edge.
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < SW_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw.i_sw;
            sync2_q   <= sync1_q;
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < SW_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw.o_sw      = sw_q;
    assign sw.o_rise    = rise_q;
    assign sw.o_fall    = fall_q;
    assign sw.o_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: one instance with DEBOUNCE_COUNT=4, one with DEBOUNCE_COUNT=1.
module tb_sw_debounce;

    logic clock;
    logic i_reset;
    int   n_checks;
    int   n_fail;

    sw_debounce_if #(.SW_WIDTH(4)) ifa ();
    sw_debounce_if #(.SW_WIDTH(4)) ifb ();

    sw_debounce #(
        .SW_WIDTH      (4),
        .DEBOUNCE_COUNT(4),
        .CNT_WIDTH     (21)
    ) dut_a (
        .clock  (clock),
        .i_reset(i_reset),
        .sw     (ifa.slave)
    );

    sw_debounce #(
        .SW_WIDTH      (4),
        .DEBOUNCE_COUNT(1),
        .CNT_WIDTH     (21)
    ) dut_b (
        .clock  (clock),
        .i_reset(i_reset),
        .sw     (ifb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [3:0] sw_e, input logic [3:0] rise_e,
                            input logic [3:0] fall_e, input logic chg_e);
        check({tag, " a.o_sw"}, ifa.o_sw, sw_e);
        check({tag, " a.o_rise"}, ifa.o_rise, rise_e);
        check({tag, " a.o_fall"}, ifa.o_fall, fall_e);
        check({tag, " a.o_changed"}, {3'b000, ifa.o_changed}, {3'b000, chg_e});
    endtask

    task automatic expect_b(input string tag, input logic [3:0] sw_e, input logic [3:0] rise_e,
                            input logic [3:0] fall_e, input logic chg_e);
        check({tag, " b.o_sw"}, ifb.o_sw, sw_e);
        check({tag, " b.o_rise"}, ifb.o_rise, rise_e);
        check({tag, " b.o_fall"}, ifb.o_fall, fall_e);
        check({tag, " b.o_changed"}, {3'b000, ifb.o_changed}, {3'b000, chg_e});
    endtask

    // Advance one rising edge and settle before sampling / driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Apply new_sw to instance a before the next edge (edge 1) and watch 8 edges:
    // the transition is expected exactly at edge 6 (DEBOUNCE_COUNT + 2).
    task automatic edge_a(input string tag, input logic [3:0] old_sw, input logic [3:0] new_sw);
        logic [3:0] r, f;
        r = new_sw & ~old_sw;
        f = old_sw & ~new_sw;
        ifa.i_sw = new_sw;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k < 6) expect_a($sformatf("%s e%0d", tag, k), old_sw, 4'b0, 4'b0, 1'b0);
            else if (k == 6) expect_a($sformatf("%s e%0d", tag, k), new_sw, r, f, |(r | f));
            else expect_a($sformatf("%s e%0d", tag, k), new_sw, 4'b0, 4'b0, 1'b0);
        end
    endtask

    initial begin
        logic       b0;
        n_checks = 0;
        n_fail   = 0;
        i_reset  = 1'b0;
        ifa.i_sw = 4'b0000;
        ifb.i_sw = 4'b0000;
        #1;
        expect_a("reset t0", 4'b0, 4'b0, 4'b0, 1'b0);
        expect_b("reset t0", 4'b0, 4'b0, 4'b0, 1'b0);
        step();
        step();
        i_reset = 1'b1;

        // Quiet hold with all switches low.
        for (int k = 1; k <= 20; k++) begin
            step();
            expect_a($sformatf("idle e%0d", k), 4'b0, 4'b0, 4'b0, 1'b0);
        end

        // Clean rising edge on bit 0.
        edge_a("clean", 4'b0000, 4'b0001);

        // 3-cycle glitch on bit 2 is rejected.
        ifa.i_sw = 4'b0101;
        step();
        step();
        step();
        ifa.i_sw = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            expect_a($sformatf("glitch e%0d", k), 4'b0001, 4'b0, 4'b0, 1'b0);
        end

        // Bounce 1,0 then held 1: one rise, 6 edges after the last 0->1.
        ifa.i_sw = 4'b0101;
        step();
        expect_a("bounce hi", 4'b0001, 4'b0, 4'b0, 1'b0);
        ifa.i_sw = 4'b0001;
        step();
        expect_a("bounce lo", 4'b0001, 4'b0, 4'b0, 1'b0);
        edge_a("bounce", 4'b0001, 4'b0101);

        // Two simultaneous falls, then the simultaneous-update cases.
        edge_a("clear", 4'b0101, 4'b0000);
        edge_a("simul rise", 4'b0000, 4'b1010);
        edge_a("simul fall", 4'b1010, 4'b0010);

        // Reset asserted mid-count clears everything immediately.
        ifa.i_sw = 4'b1111;
        step();
        step();
        step();
        i_reset = 1'b0;
        #1;
        expect_a("midreset", 4'b0, 4'b0, 4'b0, 1'b0);
        step();
        expect_a("midreset held", 4'b0, 4'b0, 4'b0, 1'b0);
        i_reset = 1'b1;
        edge_a("post reset", 4'b0000, 4'b1111);

        // DEBOUNCE_COUNT=1: bit 0 toggles every 4 cycles, accepted at edge 3.
        b0 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            b0 = ~b0;
            ifb.i_sw = {3'b000, b0};
            for (int k = 1; k <= 4; k++) begin
                step();
                if (k < 3)
                    expect_b($sformatf("dc1 t%0d e%0d", t, k), {3'b000, ~b0}, 4'b0, 4'b0, 1'b0);
                else if (k == 3)
                    expect_b($sformatf("dc1 t%0d e%0d", t, k), {3'b000, b0}, {3'b000, b0},
                             {3'b000, ~b0}, 1'b1);
                else
                    expect_b($sformatf("dc1 t%0d e%0d", t, k), {3'b000, b0}, 4'b0, 4'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
